// File: rtl/w0rm_interrupt_arbiter.sv
// w0rm_interrupt_arbiter
// Shares the core's single peripheral interrupt request between NUM_SOURCES
// requesters: rising-edge capture into a pending register, masking, winner
// selection, and a request/service handshake with the core interrupt unit.
// Optional build macro: W0RM_IRQ_ROUND_ROBIN_EN selects rotating priority
// starting after the last serviced source; otherwise the lowest index wins.
module w0rm_interrupt_arbiter #(
  parameter int unsigned NUM_SOURCES = 8,
  parameter int unsigned ISR_WIDTH   = 8,
  parameter int unsigned ISR_BASE    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] irq_req,
  input  logic                   mask_we,
  input  logic [NUM_SOURCES-1:0] mask_wdata,
  input  logic                   core_interrupt,
  input  logic                   isr_addr_valid,
  input  logic                   isr_return,
  output logic                   peripheral_interrupt,
  output logic [ISR_WIDTH-1:0]   peripheral_isr_number,
  output logic [NUM_SOURCES-1:0] irq_pending,
  output logic [NUM_SOURCES-1:0] irq_mask,
  output logic                   in_service
);

  localparam int unsigned SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    SERVICE   = 2'd2,
    CORE_WAIT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_SOURCES-1:0] irq_req_q;
  logic                   core_int_q;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] mask_q, mask_d;
  logic [NUM_SOURCES-1:0] pend_clr;
  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] elig_sh;
  logic [SW-1:0]          grant_q, grant_d;
  logic [SW-1:0]          winner;
  logic                   win_valid;
  logic                   pi_q, pi_d;
  logic [ISR_WIDTH-1:0]   num_q, num_d;
  logic                   insv_q, insv_d;
`ifdef W0RM_IRQ_ROUND_ROBIN_EN
  logic [SW-1:0]          last_q, last_d;
  int unsigned            rr_idx;
`endif

  assign eligible = pending_q & mask_q;

  // Winner selection among eligible sources
  always_comb begin
    winner    = '0;
    win_valid = 1'b0;
    elig_sh   = '0;
`ifdef W0RM_IRQ_ROUND_ROBIN_EN
    rr_idx    = 0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      rr_idx  = (32'(last_q) + 32'd1 + k) % NUM_SOURCES;
      elig_sh = eligible >> rr_idx;
      if (!win_valid && elig_sh[0]) begin
        winner    = SW'(rr_idx);
        win_valid = 1'b1;
      end
    end
`else
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      elig_sh = eligible >> k;
      if (!win_valid && elig_sh[0]) begin
        winner    = SW'(k);
        win_valid = 1'b1;
      end
    end
`endif
  end

  // Request/service FSM next state and registered-output next values
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    pi_d     = pi_q;
    num_d    = num_q;
    insv_d   = insv_q;
    pend_clr = '0;
`ifdef W0RM_IRQ_ROUND_ROBIN_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_valid && !core_interrupt) begin
          grant_d = winner;
          pi_d    = 1'b1;
          num_d   = ISR_WIDTH'(ISR_BASE + 32'(winner));
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        if (isr_addr_valid) begin
          pi_d = 1'b0;
          // The core took its own vector 0: our source stays pending.
          if (core_int_q) begin
            state_d = CORE_WAIT;
          end else begin
            pend_clr = NUM_SOURCES'(1) << grant_q;
            insv_d   = 1'b1;
            state_d  = SERVICE;
`ifdef W0RM_IRQ_ROUND_ROBIN_EN
            last_d   = grant_q;
`endif
          end
        end
      end
      SERVICE: begin
        if (isr_return) begin
          insv_d  = 1'b0;
          state_d = IDLE;
        end
      end
      CORE_WAIT: begin
        if (isr_return) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending update: a fresh rising edge overrides a same-cycle clear
  always_comb begin
    pending_d = (pending_q & ~pend_clr) | (irq_req & ~irq_req_q);
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irq_req_q  <= '0;
      core_int_q <= 1'b0;
      pending_q  <= '0;
      mask_q     <= '0;
      grant_q    <= '0;
      pi_q       <= 1'b0;
      num_q      <= '0;
      insv_q     <= 1'b0;
`ifdef W0RM_IRQ_ROUND_ROBIN_EN
      last_q     <= SW'(NUM_SOURCES - 1);
`endif
    end else begin
      state_q    <= state_d;
      irq_req_q  <= irq_req;
      core_int_q <= core_interrupt;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      grant_q    <= grant_d;
      pi_q       <= pi_d;
      num_q      <= num_d;
      insv_q     <= insv_d;
`ifdef W0RM_IRQ_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign peripheral_interrupt  = pi_q;
  assign peripheral_isr_number = num_q;
  assign irq_pending           = pending_q;
  assign irq_mask              = mask_q;
  assign in_service            = insv_q;

endmodule

// File: tb/tb_w0rm_interrupt_arbiter.sv
// Testbench for w0rm_interrupt_arbiter: table of per-cycle input vectors with
// expected outputs after the following clock edge, checked through a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_w0rm_interrupt_arbiter;

`ifdef W0RM_IRQ_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_req = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = '0;
  logic       core_interrupt = 1'b0;
  logic       isr_addr_valid = 1'b0;
  logic       isr_return = 1'b0;
  logic       peripheral_interrupt;
  logic [7:0] peripheral_isr_number;
  logic [7:0] irq_pending;
  logic [7:0] irq_mask;
  logic       in_service;

  int n_checks = 0;
  int n_fail   = 0;

  w0rm_interrupt_arbiter #(
    .NUM_SOURCES (8),
    .ISR_WIDTH   (8),
    .ISR_BASE    (1)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .irq_req               (irq_req),
    .mask_we               (mask_we),
    .mask_wdata            (mask_wdata),
    .core_interrupt        (core_interrupt),
    .isr_addr_valid        (isr_addr_valid),
    .isr_return            (isr_return),
    .peripheral_interrupt  (peripheral_interrupt),
    .peripheral_isr_number (peripheral_isr_number),
    .irq_pending           (irq_pending),
    .irq_mask              (irq_mask),
    .in_service            (in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irq;
    logic       we;
    logic [7:0] wd;
    logic       ci;
    logic       av;
    logic       ret;
    logic       pi;
    logic [7:0] num;
    logic [7:0] pend;
    logic [7:0] mask;
    logic       insv;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   sb_row[$];

  function automatic vec_t mk(logic [7:0] irq, logic we, logic [7:0] wd,
                              logic ci, logic av, logic ret,
                              logic pi, logic [7:0] num, logic [7:0] pend,
                              logic [7:0] mask, logic insv);
    vec_t v;
    v.irq = irq; v.we = we; v.wd = wd; v.ci = ci; v.av = av; v.ret = ret;
    v.pi = pi; v.num = num; v.pend = pend; v.mask = mask; v.insv = insv;
    return v;
  endfunction

  task automatic chk(string name, int row, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic sb_compare();
    vec_t v;
    int   r;
    v = sb.pop_front();
    r = sb_row.pop_front();
    chk("peripheral_interrupt", r, 8'(peripheral_interrupt), 8'(v.pi));
    chk("isr_number", r, peripheral_isr_number, v.num);
    chk("irq_pending", r, irq_pending, v.pend);
    chk("irq_mask", r, irq_mask, v.mask);
    chk("in_service", r, 8'(in_service), 8'(v.insv));
  endtask

  task automatic drive(vec_t v);
    irq_req        = v.irq;
    mask_we        = v.we;
    mask_wdata     = v.wd;
    core_interrupt = v.ci;
    isr_addr_valid = v.av;
    isr_return     = v.ret;
  endtask

  initial begin
    // irq we wd ci av ret | pi num pend mask insv
    // single source 3, mask write during REQUEST, ret ignored in REQUEST
    tbl.push_back(mk(8'h00,1,8'hFF,0,0,0, 0,8'h00,8'h00,8'hFF,0));
    tbl.push_back(mk(8'h08,0,8'h00,0,0,0, 0,8'h00,8'h08,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,8'h04,8'h08,8'hFF,0));
    tbl.push_back(mk(8'h00,1,8'hF7,0,0,1, 1,8'h04,8'h08,8'hF7,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,8'h04,8'h00,8'hF7,1));
    tbl.push_back(mk(8'h00,1,8'hFF,0,0,0, 0,8'h04,8'h00,8'hFF,1));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1, 0,8'h04,8'h00,8'hFF,0));
    // masked source 2 stays pending, unmask releases it
    tbl.push_back(mk(8'h00,1,8'h00,0,0,0, 0,8'h04,8'h00,8'h00,0));
    tbl.push_back(mk(8'h04,0,8'h00,0,0,0, 0,8'h04,8'h04,8'h00,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 0,8'h04,8'h04,8'h00,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 0,8'h04,8'h04,8'h00,0));
    tbl.push_back(mk(8'h00,1,8'h04,0,0,0, 0,8'h04,8'h04,8'h04,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,8'h03,8'h04,8'h04,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,8'h03,8'h00,8'h04,1));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1, 0,8'h03,8'h00,8'h04,0));
    // sources 5 and 1 together; one idle cycle between services
    tbl.push_back(mk(8'h00,1,8'hFF,0,0,0, 0,8'h03,8'h00,8'hFF,0));
    tbl.push_back(mk(8'h22,0,8'h00,0,0,0, 0,8'h03,8'h22,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,RR?8'h06:8'h02,8'h22,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,RR?8'h06:8'h02,RR?8'h02:8'h20,8'hFF,1));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1, 0,RR?8'h06:8'h02,RR?8'h02:8'h20,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,RR?8'h02:8'h06,RR?8'h02:8'h20,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,RR?8'h02:8'h06,8'h00,8'hFF,1));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1, 0,RR?8'h02:8'h06,8'h00,8'hFF,0));
    // core takes vector 0 during REQUEST for source 0
    tbl.push_back(mk(8'h01,0,8'h00,0,0,0, 0,RR?8'h02:8'h06,8'h01,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,8'h01,8'h01,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,1,0,0, 1,8'h01,8'h01,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,1,1,0, 0,8'h01,8'h01,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 0,8'h01,8'h01,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1, 0,8'h01,8'h01,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,8'h01,8'h01,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,8'h01,8'h00,8'hFF,1));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1, 0,8'h01,8'h00,8'hFF,0));
    // source 4 held high: one set only; av ignored in SERVICE
    tbl.push_back(mk(8'h10,0,8'h00,0,0,0, 0,8'h01,8'h10,8'hFF,0));
    tbl.push_back(mk(8'h10,0,8'h00,0,0,0, 1,8'h05,8'h10,8'hFF,0));
    tbl.push_back(mk(8'h10,0,8'h00,0,1,0, 0,8'h05,8'h00,8'hFF,1));
    tbl.push_back(mk(8'h10,0,8'h00,0,1,0, 0,8'h05,8'h00,8'hFF,1));
    tbl.push_back(mk(8'h10,0,8'h00,0,0,1, 0,8'h05,8'h00,8'hFF,0));
    tbl.push_back(mk(8'h10,0,8'h00,0,0,0, 0,8'h05,8'h00,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 0,8'h05,8'h00,8'hFF,0));
    tbl.push_back(mk(8'h10,0,8'h00,0,0,0, 0,8'h05,8'h10,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,8'h05,8'h10,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,8'h05,8'h00,8'hFF,1));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1, 0,8'h05,8'h00,8'hFF,0));
    // new edge on the granted bit in the clearing cycle: set wins
    tbl.push_back(mk(8'h10,0,8'h00,0,0,0, 0,8'h05,8'h10,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,8'h05,8'h10,8'hFF,0));
    tbl.push_back(mk(8'h10,0,8'h00,0,1,0, 0,8'h05,8'h10,8'hFF,1));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1, 0,8'h05,8'h10,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,0, 1,8'h05,8'h10,8'hFF,0));
    tbl.push_back(mk(8'h00,0,8'h00,0,1,0, 0,8'h05,8'h00,8'hFF,1));
    tbl.push_back(mk(8'h00,0,8'h00,0,0,1, 0,8'h05,8'h00,8'hFF,0));

    // reset state
    @(negedge clk);
    chk("reset_pi", -1, 8'(peripheral_interrupt), 8'h00);
    chk("reset_num", -1, peripheral_isr_number, 8'h00);
    chk("reset_pending", -1, irq_pending, 8'h00);
    chk("reset_mask", -1, irq_mask, 8'h00);
    chk("reset_in_service", -1, 8'(in_service), 8'h00);
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      if (sb.size() > 0) sb_compare();
      drive(tbl[r]);
      sb.push_back(tbl[r]);
      sb_row.push_back(r);
    end
    @(negedge clk);
    sb_compare();
    drive(mk(8'h00,0,8'h00,0,0,0, 0,8'h00,8'h00,8'h00,0));

    // asynchronous reset in the middle of SERVICE
    irq_req = 8'h42;
    @(negedge clk);
    irq_req = 8'h00;
    @(negedge clk);
    isr_addr_valid = 1'b1;
    @(negedge clk);
    isr_addr_valid = 1'b0;
    chk("pre_reset_in_service", 100, 8'(in_service), 8'h01);
    chk("pre_reset_num", 100, peripheral_isr_number, 8'h02);
    chk("pre_reset_pending", 100, irq_pending, 8'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pi", 101, 8'(peripheral_interrupt), 8'h00);
    chk("async_reset_num", 101, peripheral_isr_number, 8'h00);
    chk("async_reset_pending", 101, irq_pending, 8'h00);
    chk("async_reset_mask", 101, irq_mask, 8'h00);
    chk("async_reset_in_service", 101, 8'(in_service), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_pi", 102, 8'(peripheral_interrupt), 8'h00);
    chk("post_reset_in_service", 102, 8'(in_service), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/w0rm_interrupt_arbiter.md
Name: w0rm_interrupt_arbiter

Overview:
Shares the single peripheral interrupt request port of the W0RM core interrupt unit between NUM_SOURCES peripheral requesters. Edge-detects and latches requests, masks them, selects a winner, and presents it as peripheral_interrupt plus a vector number. Holds that request until the core accepts it, then tracks the service window until isr_return. Sits between the peripheral bus/IRQ lines and the core interrupt unit.

Parameters:
NUM_SOURCES, 8, number of peripheral request lines (1..255).
ISR_WIDTH, 8, width of the vector number sent to the core.
ISR_BASE, 1, vector assigned to source 0; source i gets ISR_BASE+i (vector 0 is reserved for core_interrupt).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
irq_req  in  NUM_SOURCES  peripheral request lines; a rising edge sets pending.
mask_we  in  1  write strobe for the mask register.
mask_wdata  in  NUM_SOURCES  new mask value; 1 = source enabled.
core_interrupt  in  1  core-internal interrupt, same signal the core interrupt unit sees.
isr_addr_valid  in  1  core interrupt unit acceptance pulse.
isr_return  in  1  ISR return strobe from the core.
peripheral_interrupt  out  1  request to the core interrupt unit.
peripheral_isr_number  out  ISR_WIDTH  vector of the granted source.
irq_pending  out  NUM_SOURCES  current pending register.
irq_mask  out  NUM_SOURCES  current mask register.
in_service  out  1  high while a peripheral ISR is running.

Behaviour:
- Reset (async, rst_n=0): pending=0, mask=0, irq_req_d=0, core_interrupt_d=0, state=IDLE, grant=0. peripheral_interrupt=0, peripheral_isr_number=0, in_service=0.
- Edge detect: pending[i] is set on the cycle after irq_req[i] goes 0->1, using the registered irq_req_d. A set and a clear on the same bit in the same cycle: the set wins.
- Mask: on mask_we, mask <= mask_wdata on the next edge. Masked bits stay pending but are not arbitrated.
- eligible = pending & mask. Fixed priority: the lowest index wins.
- States:
  - IDLE: if eligible != 0 and core_interrupt=0, latch grant = winner and go to REQUEST. peripheral_interrupt and peripheral_isr_number (= ISR_BASE+grant, truncated to ISR_WIDTH) are registered, so they assert 1 cycle after entry.
  - REQUEST: peripheral_interrupt=1, vector held stable. On isr_addr_valid=1:
    - if core_interrupt_d=1, the core took vector 0: deassert the request, keep pending[grant], go to CORE_WAIT.
    - otherwise clear pending[grant], deassert the request, go to SERVICE with in_service=1.
  - A masked grant never retracts a request already in REQUEST.
  - SERVICE: on isr_return, in_service=0 and go to IDLE. A new winner may be requested on the following cycle (minimum 1 idle cycle), so back-to-back requests do not overlap the core's return/re-entry path.
  - CORE_WAIT: on isr_return, go to IDLE.
- Any state, rst_n low: immediate return to reset values. A pending ISR is lost and the core is responsible for its own state.
- isr_return in IDLE or REQUEST: ignored.
- isr_addr_valid outside REQUEST: ignored.

Optional Feature:
Macro W0RM_IRQ_ROUND_ROBIN_EN.
- Defined: rotating priority. Search starts at (last_serviced+1) mod NUM_SOURCES. last_serviced updates when entering SERVICE and resets to NUM_SOURCES-1.
- Undefined: fixed lowest-index priority as above.

Test Plan:
1. Reset then mask=0xFF; pulse irq_req[3] -> pending=0x08. peripheral_interrupt=1 with number 4 within 2 cycles. After isr_addr_valid: pending=0x00, in_service=1. After isr_return: in_service=0.
2. Mask=0x00; pulse irq_req[2] -> pending=0x04 and no request. Write mask=0x04 -> request with vector 3 on the following cycles.
3. Raise irq_req[5] and irq_req[1] in the same cycle -> vector 2 serviced first, then vector 6 after isr_return plus 1 idle cycle. With W0RM_IRQ_ROUND_ROBIN_EN and last_serviced=1: vector 6 first.
4. In REQUEST for source 0, assert core_interrupt, then isr_addr_valid -> pending[0] stays 1 and state goes to CORE_WAIT. After isr_return, source 0 is re-requested with vector 1.
5. Hold irq_req[4] high continuously -> only one pending set. A second set occurs only after low then high again.
6. Assert rst_n=0 mid-SERVICE -> all outputs 0 immediately, without waiting for clk.
